// File: rtl/jtsdram_mock.sv
// jtsdram_mock: SDRAM responder that serves the prog port and four bank
// ports one request at a time from an internal 4*2**AW x 16 RAM.
// Ports: clk, rst (async, active-high); prog_* write/read port with
//   ack/rdy; ba_* four bank read ports (bank 0 may also write) with
//   per-bank ack/rdy; refresh_en; data_read = {mem[a+1], mem[a]}.
// Parameters: AW address bits per bank, LAT ack-to-rdy cycles,
//   RFSH_LEN refresh length, ERR_PER bank reads per injected error.
// Option: define JTSDRAM_ERRINJ_EN to flip data_read[0] on every
//   ERR_PER-th bank read response.
`timescale 1ns/1ps
module jtsdram_mock #(
  parameter int AW       = 8,
  parameter int LAT      = 3,
  parameter int RFSH_LEN = 4,
  parameter int ERR_PER  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic [1:0]  prog_ba,
  input  logic        prog_we,
  input  logic        prog_rd,
  output logic        prog_ack,
  output logic        prog_rdy,
  input  logic [87:0] ba_addr,
  input  logic [3:0]  ba_rd,
  input  logic        ba_wr,
  input  logic [15:0] ba0_din,
  input  logic [1:0]  ba0_din_m,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_rdy,
  input  logic        refresh_en,
  output logic [31:0] data_read
);

  localparam int DEPTH = 4 * (2 ** AW);
  localparam logic [7:0] WAIT_LAST = 8'(LAT - 2);
  localparam logic [7:0] RFSH_LAST = 8'(RFSH_LEN - 1);
  localparam logic [AW-1:0] A_ONE = AW'(1);

  typedef enum logic [2:0] {
    IDLE, ACK, WAIT, RDY, RFSH
  } state_t;

  state_t st_q, st_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    rr_q, rr_d;
  logic [1:0]    ba_q, ba_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic [1:0]    mask_q, mask_d;
  logic          we_q, we_d;
  logic          prog_q, prog_d;
  logic [31:0]   dout_q, dout_d;

  logic [15:0]   mem_q [DEPTH];

  logic [3:0]    breq;
  logic          found;
  logic [1:0]    pick, cand;
  logic [AW+1:0] idx0, idx1;
  logic [31:0]   rd_word;
  logic [15:0]   wr_word;
  logic          load_rd;

`ifdef JTSDRAM_ERRINJ_EN
  localparam int EW = $clog2(ERR_PER + 1);
  localparam logic [EW-1:0] ERR_LAST = EW'(ERR_PER - 1);
  logic [EW-1:0] err_q, err_d;
`endif

  // Upper address bits are don't-care by design.
  logic unused_ok;
  assign unused_ok = ^{prog_addr, ba_addr, 1'(ERR_PER)};

  // ba_wr shares the bank 0 slot; direction is resolved at grant.
  assign breq = {ba_rd[3:1], ba_rd[0] | ba_wr};

  // Second word wraps inside the bank.
  assign idx0 = {ba_q, addr_q};
  assign idx1 = {ba_q, addr_q + A_ONE};
  assign rd_word = {mem_q[idx1], mem_q[idx0]};
  assign wr_word = {
    mask_q[1] ? mem_q[idx0][15:8] : din_q[15:8],
    mask_q[0] ? mem_q[idx0][7:0]  : din_q[7:0]
  };

  // rr_q is the first bank to look at, i.e. one past the last served.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    cand  = rr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_q + 2'(k);
      if (!found && breq[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rr_d   = rr_q;
    ba_d   = ba_q;
    addr_d = addr_q;
    din_d  = din_q;
    mask_d = mask_q;
    we_d   = we_q;
    prog_d = prog_q;
    dout_d = dout_q;
    unique case (st_q)
      IDLE: begin
        if (refresh_en) begin
          st_d  = RFSH;
          cnt_d = '0;
        end else if (prog_we || prog_rd) begin
          st_d   = ACK;
          prog_d = 1'b1;
          we_d   = prog_we;
          ba_d   = prog_ba;
          addr_d = prog_addr[AW-1:0];
          din_d  = prog_data;
          mask_d = prog_mask;
        end else if (found) begin
          st_d   = ACK;
          prog_d = 1'b0;
          we_d   = (pick == 2'd0) && ba_wr;
          ba_d   = pick;
          addr_d = ba_addr[22*int'(pick) +: AW];
          din_d  = ba0_din;
          mask_d = ba0_din_m;
          rr_d   = pick + 2'd1;
        end
      end
      ACK: begin
        cnt_d = '0;
        st_d  = (LAT <= 1) ? RDY : WAIT;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) st_d = RDY;
        else cnt_d = cnt_q + 8'd1;
      end
      RDY: st_d = IDLE;
      RFSH: begin
        if (cnt_q == RFSH_LAST) st_d = IDLE;
        else cnt_d = cnt_q + 8'd1;
      end
      default: st_d = IDLE;
    endcase

    // Read data is captured on the edge into RDY so it is
    // valid for the whole rdy cycle.
    load_rd = (st_d == RDY) && (st_q != RDY) && !we_q;
`ifdef JTSDRAM_ERRINJ_EN
    err_d = err_q;
`endif
    if (load_rd) begin
      dout_d = rd_word;
`ifdef JTSDRAM_ERRINJ_EN
      if (!prog_q) begin
        if (err_q == ERR_LAST) begin
          err_d     = '0;
          dout_d[0] = ~rd_word[0];
        end else begin
          err_d = err_q + 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      rr_q   <= '0;
      ba_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
      mask_q <= '0;
      we_q   <= 1'b0;
      prog_q <= 1'b0;
      dout_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      ba_q   <= ba_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      mask_q <= mask_d;
      we_q   <= we_d;
      prog_q <= prog_d;
      dout_q <= dout_d;
    end
  end

`ifdef JTSDRAM_ERRINJ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end
`endif

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (st_q == RDY && we_q) mem_q[idx0] <= wr_word;
  end

  always_comb begin
    prog_ack = 1'b0;
    prog_rdy = 1'b0;
    ba_ack   = '0;
    ba_rdy   = '0;
    if (st_q == ACK) begin
      if (prog_q) prog_ack = 1'b1;
      else        ba_ack[ba_q] = 1'b1;
    end
    if (st_q == RDY) begin
      if (prog_q) prog_rdy = 1'b1;
      else        ba_rdy[ba_q] = 1'b1;
    end
  end

  assign data_read = dout_q;

endmodule

// File: tb/tb_jtsdram_mock.sv
// tb_jtsdram_mock: vector table, corner sequences and random traffic
// against a memory-array reference for jtsdram_mock.
`timescale 1ns/1ps
module tb_jtsdram_mock;

  localparam int AW = 8;
  localparam int LAT = 3;
  localparam int RFSH_LEN = 4;
  localparam int EP = 4;
  localparam int DB = 2 ** AW;

  localparam int K_PW  = 0;
  localparam int K_PR  = 1;
  localparam int K_PWR = 2;
  localparam int K_BR  = 3;
  localparam int K_BW  = 4;
  localparam int K_BWR = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [1:0]  prog_mask = '0;
  logic [1:0]  prog_ba = '0;
  logic        prog_we = 1'b0;
  logic        prog_rd = 1'b0;
  logic        prog_ack, prog_rdy;
  logic [87:0] ba_addr = '0;
  logic [3:0]  ba_rd = '0;
  logic        ba_wr = 1'b0;
  logic [15:0] ba0_din = '0;
  logic [1:0]  ba0_din_m = '0;
  logic [3:0]  ba_ack, ba_rdy;
  logic        refresh_en = 1'b0;
  logic [31:0] data_read;

  jtsdram_mock #(
    .AW(AW), .LAT(LAT), .RFSH_LEN(RFSH_LEN), .ERR_PER(EP)
  ) dut (
    .clk(clk), .rst(rst),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ba(prog_ba),
    .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_ack(prog_ack), .prog_rdy(prog_rdy),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr),
    .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .refresh_en(refresh_en), .data_read(data_read)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [1:0]  b;
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  m;
    logic [31:0] e;
    logic [31:0] em;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int failures = 0;
  int nbrd = 0;
  logic [31:0] last_exp = '0;
  logic [31:0] last_em = '1;
  logic [31:0] got_w;
  logic [15:0] ref_mem [4][DB];
  logic [1:0]  ref_ok  [4][DB];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drop_all();
    prog_we = 1'b0;
    prog_rd = 1'b0;
    ba_rd   = '0;
    ba_wr   = 1'b0;
  endtask

  task automatic model_wr(input logic [1:0] b, input logic [AW-1:0] a,
                          input logic [15:0] d, input logic [1:0] m);
    if (!m[0]) begin
      ref_mem[b][a][7:0] = d[7:0];
      ref_ok[b][a][0] = 1'b1;
    end
    if (!m[1]) begin
      ref_mem[b][a][15:8] = d[15:8];
      ref_ok[b][a][1] = 1'b1;
    end
  endtask

  task automatic model_rd(input logic [1:0] b, input logic [AW-1:0] a,
                          output logic [31:0] e, output logic [31:0] em);
    logic [AW-1:0] a1;
    a1 = AW'((int'(a) + 1) % DB);
    e  = {ref_mem[b][a1], ref_mem[b][a]};
    em = {{8{ref_ok[b][a1][1]}}, {8{ref_ok[b][a1][0]}},
          {8{ref_ok[b][a][1]}},  {8{ref_ok[b][a][0]}}};
  endtask

  function automatic logic [1:0] rr_next(input logic [1:0] last,
                                         input logic [3:0] req);
    logic [1:0] n;
    rr_next = last;
    for (int k = 4; k >= 1; k--) begin
      n = last + 2'(k);
      if (req[n]) rr_next = n;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drop_all();
    refresh_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_pulses", {28'd0, prog_ack, prog_rdy, |ba_ack, |ba_rdy}, 0);
      chk("rst_data", data_read, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    nbrd = 0;
    last_exp = '0;
    last_em = '1;
  endtask

  task automatic run_txn(input int kind, input logic [1:0] b,
                         input logic [21:0] a, input logic [15:0] d,
                         input logic [1:0] m, input bit early,
                         input logic [31:0] texp, input logic [31:0] tem,
                         output logic [31:0] got);
    bit is_wr, is_bank;
    logic [1:0] bb;
    logic [4:0] xport;
    logic [31:0] e, em;
    int ack_c, rdy_c;
    is_wr = (kind == K_PW) || (kind == K_PWR) ||
            (kind == K_BW) || (kind == K_BWR);
    is_bank = (kind >= K_BR);
    bb = (kind == K_BW || kind == K_BWR) ? 2'd0 : b;
    xport = is_bank ? {1'b0, 4'b0001 << bb} : 5'b10000;
    for (int i = 0; i < 4; i++) ba_addr[22*i +: 22] = 22'($urandom);
    prog_addr = a; prog_ba = b; prog_data = d; prog_mask = m;
    ba0_din = d; ba0_din_m = m;
    case (kind)
      K_PW:  prog_we = 1'b1;
      K_PR:  prog_rd = 1'b1;
      K_PWR: begin prog_we = 1'b1; prog_rd = 1'b1; end
      K_BR:  begin ba_addr[22*int'(bb) +: 22] = a; ba_rd[bb] = 1'b1; end
      K_BW:  begin ba_addr[21:0] = a; ba_wr = 1'b1; end
      default: begin
        ba_addr[21:0] = a; ba_wr = 1'b1; ba_rd[0] = 1'b1;
      end
    endcase
    model_rd(bb, a[AW-1:0], e, em);
`ifdef JTSDRAM_ERRINJ_EN
    if (is_bank && !is_wr) begin
      nbrd++;
      if (nbrd % EP == 0) begin
        e[0] = ~e[0];
        texp[0] = ~texp[0];
      end
    end
`endif
    ack_c = -1;
    rdy_c = -1;
    got = '0;
    for (int c = 0; c < 4 * LAT + 20 && rdy_c < 0; c++) begin
      @(negedge clk);
      if ({prog_ack, ba_ack} != 5'd0) begin
        if (ack_c >= 0) chk("ack_once", c, ack_c);
        else ack_c = c;
        chk("ack_port", {27'd0, prog_ack, ba_ack}, {27'd0, xport});
      end
      if ({prog_rdy, ba_rdy} != 5'd0) begin
        rdy_c = c;
        got = data_read;
        chk("rdy_port", {27'd0, prog_rdy, ba_rdy}, {27'd0, xport});
      end
      @(posedge clk); #1;
      if (early && c == ack_c) drop_all();
    end
    drop_all();
    chk("ack_cycle", ack_c, 1);
    chk("rdy_cycle", rdy_c, LAT + 1);
    if (is_wr) begin
      chk("data_hold", got & last_em, last_exp & last_em);
      model_wr(bb, a[AW-1:0], d, m);
    end else begin
      chk("rd_model", got & em, e & em);
      if (tem != 0) chk("rd_table", got & tem, texp & tem);
      last_exp = e;
      last_em = em;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  last_b;
    logic [3:0]  req;
    logic [4:0]  xa, xr;
    logic [21:0] ra;
    int n_ack, lo, a2;

    for (int b = 0; b < 4; b++)
      for (int i = 0; i < DB; i++) begin
        ref_ok[b][i] = 2'b00;
        ref_mem[b][i] = '0;
      end

    do_reset();

    // round robin: all four held, then banks 1 and 3 only
    last_b = 2'd3;
    for (int ph = 0; ph < 2; ph++) begin
      req = (ph == 0) ? 4'hF : 4'b1010;
      ba_rd = req;
      n_ack = 0;
      for (int c = 0; c < 200 && n_ack < (ph == 0 ? 8 : 4); c++) begin
        @(negedge clk);
        if (ba_ack != 4'd0) begin
          last_b = rr_next(last_b, req);
          chk("rr_order", {28'd0, ba_ack}, {28'd0, 4'b0001 << last_b});
          n_ack++;
        end
        @(posedge clk); #1;
      end
      ba_rd = '0;
      chk("rr_count", n_ack, ph == 0 ? 8 : 4);
      repeat (LAT + 4) @(posedge clk);
      #1;
    end

    do_reset();

    tbl.push_back('{K_PW,  2'd1, 22'd5,       16'hA55A, 2'b00, 0, 0});
    tbl.push_back('{K_BR,  2'd1, 22'd5,       16'h0, 2'b00, 32'h0000A55A, 32'h0000FFFF});
    tbl.push_back('{K_BW,  2'd0, 22'd255,     16'h1234, 2'b00, 0, 0});
    tbl.push_back('{K_BW,  2'd0, 22'd0,       16'hBEEF, 2'b00, 0, 0});
    tbl.push_back('{K_BR,  2'd0, 22'd255,     16'h0, 2'b00, 32'hBEEF1234, 32'hFFFFFFFF});
    tbl.push_back('{K_PR,  2'd0, 22'd255,     16'h0, 2'b00, 32'hBEEF1234, 32'hFFFFFFFF});
    tbl.push_back('{K_BW,  2'd0, 22'd20,      16'h0000, 2'b00, 0, 0});
    tbl.push_back('{K_BW,  2'd0, 22'd20,      16'hFFFF, 2'b10, 0, 0});
    tbl.push_back('{K_BR,  2'd0, 22'd20,      16'h0, 2'b00, 32'h000000FF, 32'h0000FFFF});
    tbl.push_back('{K_PW,  2'd3, 22'd7,       16'hCDCD, 2'b00, 0, 0});
    tbl.push_back('{K_PWR, 2'd3, 22'd7,       16'h1234, 2'b01, 0, 0});
    tbl.push_back('{K_PR,  2'd3, 22'd7,       16'h0, 2'b00, 32'h000012CD, 32'h0000FFFF});
    tbl.push_back('{K_BWR, 2'd0, 22'd21,      16'h5678, 2'b00, 0, 0});
    tbl.push_back('{K_BR,  2'd0, 22'd20,      16'h0, 2'b00, 32'h567800FF, 32'hFFFFFFFF});
    tbl.push_back('{K_PW,  2'd2, 22'd255,     16'h1111, 2'b00, 0, 0});
    tbl.push_back('{K_PW,  2'd2, 22'd0,       16'h2222, 2'b00, 0, 0});
    tbl.push_back('{K_BR,  2'd2, 22'd255,     16'h0, 2'b00, 32'h22221111, 32'hFFFFFFFF});
    tbl.push_back('{K_PW,  2'd1, 22'h02AB06,  16'h0606, 2'b00, 0, 0});
    tbl.push_back('{K_BR,  2'd1, 22'h3FFF05,  16'h0, 2'b00, 32'h0606A55A, 32'hFFFFFFFF});
    foreach (tbl[i])
      run_txn(tbl[i].kind, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].m,
              1'b0, tbl[i].e, tbl[i].em, got_w);

    // requests dropped right after ack still complete
    run_txn(K_PW, 2'd1, 22'd9, 16'h9999, 2'b00, 1'b1, 0, 0, got_w);
    run_txn(K_BR, 2'd1, 22'd9, 16'h0, 2'b00, 1'b1,
            32'h00009999, 32'h0000FFFF, got_w);

    // refresh raised during WAIT, bank 2 pending behind it
    for (int i = 0; i < 4; i++) ba_addr[22*i +: 22] = 22'($urandom);
    ba_rd = 4'b0001;
    a2 = LAT + 4 + RFSH_LEN;
    for (int c = 0; c <= a2 + LAT; c++) begin
      @(negedge clk);
      xa = (c == 1) ? 5'b00001 : (c == a2) ? 5'b00100 : 5'b0;
      xr = (c == LAT + 1) ? 5'b00001 : (c == a2 + LAT) ? 5'b00100 : 5'b0;
      chk("rfsh_ack", {27'd0, prog_ack, ba_ack}, {27'd0, xa});
      chk("rfsh_rdy", {27'd0, prog_rdy, ba_rdy}, {27'd0, xr});
      @(posedge clk); #1;
      if (c == 1) begin refresh_en = 1'b1; ba_rd[2] = 1'b1; end
      if (c == LAT + 1) ba_rd[0] = 1'b0;
      if (c == LAT + 2) refresh_en = 1'b0;
    end
    ba_rd = '0;
    nbrd += 2;
    last_em = '0;

    // reset while a bank 2 read is in flight; request stays held
    ba_addr[44 +: 22] = 22'd5;
    ba_rd[2] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (c == 1) chk("mid_ack", {28'd0, ba_ack}, 32'h4);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_quiet", {28'd0, prog_ack, prog_rdy, |ba_ack, |ba_rdy}, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    nbrd = 0;
    last_exp = '0;
    last_em = '1;
    run_txn(K_BR, 2'd2, 22'd5, 16'h0, 2'b00, 1'b0, 0, 0, got_w);

    // random traffic against the reference array
    for (int n = 0; n < 80; n++) begin
      lo = $urandom_range(0, 9);
      lo = (lo < 8) ? lo : DB - 1 - (lo - 8);
      ra = 22'($urandom);
      ra[AW-1:0] = AW'(lo);
      run_txn($urandom_range(0, 5), 2'($urandom_range(0, 3)), ra,
              16'($urandom), 2'($urandom_range(0, 3)), 1'b0, 0, 0, got_w);
    end

`ifdef JTSDRAM_ERRINJ_EN
    do_reset();
    run_txn(K_PW, 2'd0, 22'd30, 16'h0000, 2'b00, 1'b0, 0, 0, got_w);
    for (int i = 0; i < 8; i++) begin
      run_txn(K_BR, 2'd0, 22'd30, 16'h0, 2'b00, 1'b0,
              32'h0, 32'h0000FFFF, got_w);
      chk("errinj_bit0", {31'd0, got_w[0]}, (i == 3 || i == 7) ? 1 : 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
